gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: ADDRESS_SIZE, default 4, number of memory address bits; pointer width is ADDRESS_SIZE+1.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: inc  input  1  increment request.
REQ-005 Port: not_full_or_not_empty  input  1  qualifier; 1 = FIFO not full (write side) / not empty (read side).
REQ-006 Port: binary_address  output  ADDRESS_SIZE  memory address, registered binary count low bits.
REQ-007 Port: gray_pointer  output  ADDRESS_SIZE+1  registered Gray-coded pointer for clock-domain crossing.
REQ-008 Port: gray_pointer_next  output  ADDRESS_SIZE+1  combinational Gray code of next count value.

Function
REQ-009 Internal state: binary register bin, ADDRESS_SIZE+1 bits, and Gray register gray, ADDRESS_SIZE+1 bits.
REQ-010 Enable en = inc AND not_full_or_not_empty.
REQ-011 bin_next = bin + en, modulo 2^(ADDRESS_SIZE+1).
REQ-012 gray_pointer_next = bin_next XOR (bin_next >> 1), purely combinational, same-cycle response to inc/qualifier changes.
REQ-013 On each rising clk edge with reset deasserted: bin <= bin_next; gray <= gray_pointer_next.
REQ-014 binary_address = bin[ADDRESS_SIZE-1:0]; gray_pointer = gray; both glitch-free register outputs, one-cycle latency from en.
REQ-015 en = 0 (inc=0 or qualifier=0): bin and gray hold; gray_pointer_next equals gray_pointer.
REQ-016 Wrap-around: bin all-ones plus en -> bin 0, gray 0; MSB of bin/gray toggles every 2^ADDRESS_SIZE increments (wrap flag for full/empty compare).
REQ-017 Consecutive gray_pointer values differ in exactly one bit, including across wrap.
REQ-018 inc held high across cycles with qualifier high: increments once per cycle, no saturation.
REQ-019 Inputs X-free assumption not required for reset path; reset overrides any simultaneous en.

Reset
REQ-020 reset = 0 asynchronously forces bin and gray to 0, independent of clk.
REQ-021 During reset: binary_address = 0, gray_pointer = 0, gray_pointer_next = Gray(0 + en).
REQ-022 Reset assertion mid-count clears state immediately; counting resumes from 0 on first rising edge after deassertion.

Structure
REQ-023 No shared package required; ADDRESS_SIZE is a module parameter overridden by the FIFO top.
REQ-024 One natural sub-module: bin2gray (parameterised width, combinational XOR-shift), used for gray_pointer_next.
REQ-025 Same module instanced twice in async FIFO: write pointer (qualifier = not full) and read pointer (qualifier = not empty).

Verification (ADDRESS_SIZE = 4)
REQ-026 reset=0 pulse mid-run, any inputs -> binary_address=0, gray_pointer=00000 immediately, without clock edge.
REQ-027 After reset, inc=1, not_full_or_not_empty=0 for 5 cycles -> outputs hold 0; gray_pointer_next=00000.
REQ-028 inc=1, qualifier=1 for 4 edges -> binary_address=4, gray_pointer=00110, gray_pointer_next=00111.
REQ-029 16 enabled edges from 0 -> binary_address=0, gray_pointer=11000; 32 edges -> all zero (full wrap).
REQ-030 qualifier=1, inc toggled 0 -> count holds, gray_pointer_next=gray_pointer; every enabled step changes gray_pointer by exactly one bit (checker over 64 steps).

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared constants for the Gray-coded FIFO pointer counter.
// Its users import this package to pick up the default address width.
package gray_counter_pkg;

    localparam int unsigned DEFAULT_ADDRESS_SIZE = 4;

endpackage : gray_counter_pkg

// File: rtl/gray_counter_bin2gray.sv
// Binary to reflected-Gray conversion.
// Purely combinational XOR of the value with itself shifted right by one.
module gray_counter_bin2gray #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : gray_counter_bin2gray

// File: rtl/gray_counter.sv
// Async-FIFO pointer: a binary count that addresses the memory, plus a registered Gray copy for the other clock domain.
// The extra MSB toggles once per lap, so the pointer compare can tell full from empty.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    not_full_or_not_empty,
    output logic [ADDRESS_SIZE-1:0] binary_address,
    output logic [ADDRESS_SIZE:0]   gray_pointer,
    output logic [ADDRESS_SIZE:0]   gray_pointer_next
);

    localparam int unsigned PTR_W = ADDRESS_SIZE + 1;

    logic [PTR_W-1:0] bin;
    logic [PTR_W-1:0] gray;
    logic [PTR_W-1:0] bin_next;
    logic             en;

    assign en       = inc & not_full_or_not_empty;
    assign bin_next = bin + {{(PTR_W-1){1'b0}}, en};

    gray_counter_bin2gray #(
        .WIDTH (PTR_W)
    ) u_bin2gray (
        .bin  (bin_next),
        .gray (gray_pointer_next)
    );

    // Gray is registered from the converter, not derived from bin downstream,
    // so the value crossing clock domains comes straight off a flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_pointer_next;
        end
    end

    assign binary_address = bin[ADDRESS_SIZE-1:0];
    assign gray_pointer   = gray;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter with ADDRESS_SIZE = 4.
// A running integer count is the reference; the expected pointers are that count reduced modulo 32.
module tb_gray_counter;

    localparam int AS  = 4;
    localparam int MOD = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          inc;
    logic          qual;
    logic [AS-1:0] binary_address;
    logic [AS:0]   gray_pointer;
    logic [AS:0]   gray_pointer_next;

    int count;
    int tests;
    int failed;

    gray_counter #(
        .ADDRESS_SIZE (AS)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .inc                   (inc),
        .not_full_or_not_empty (qual),
        .binary_address        (binary_address),
        .gray_pointer          (gray_pointer),
        .gray_pointer_next     (gray_pointer_next)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int v);
        int m;
        m = v % MOD;
        return m ^ (m >> 1);
    endfunction

    task automatic check(input string tag, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic drive(input logic i, input logic q);
        inc  = i;
        qual = q;
        #1;
        check("gray_next", int'(gray_pointer_next), gray_of(count + ((i && q) ? 1 : 0)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset && inc && qual) count = (count + 1) % MOD;
        #1;
        check("bin_addr", int'(binary_address), count % (1 << AS));
        check("gray_ptr", int'(gray_pointer), gray_of(count));
    endtask

    task automatic async_reset();
        reset = 1'b0;
        count = 0;
        #1;
        check("rst_addr", int'(binary_address), 0);
        check("rst_gray", int'(gray_pointer), 0);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [AS:0] prev;
        logic        i;
        logic        q;

        tests  = 0;
        failed = 0;
        count  = 0;
        reset  = 1'b0;
        inc    = 1'b1;
        qual   = 1'b1;
        #2;
        check("por_addr", int'(binary_address), 0);
        check("por_gray", int'(gray_pointer), 0);
        check("por_next", int'(gray_pointer_next), 1);

        // Reset held across an edge with en high must keep the state at zero.
        tick();
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b0);

        // Qualifier low: five edges with inc high must not move anything.
        for (int k = 0; k < 5; k++) tick();
        check("hold_next", int'(gray_pointer_next), 0);

        drive(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check("four_addr", int'(binary_address), 4);
        check("four_gray", int'(gray_pointer), 5'b00110);
        check("four_next", int'(gray_pointer_next), 5'b00111);

        // Asynchronous clear between edges, then a full two-lap run.
        #3;
        async_reset();
        for (int k = 0; k < 16; k++) tick();
        check("lap_addr", int'(binary_address), 0);
        check("lap_gray", int'(gray_pointer), 5'b11000);
        for (int k = 0; k < 16; k++) tick();
        check("wrap_addr", int'(binary_address), 0);
        check("wrap_gray", int'(gray_pointer), 0);

        // Random inc/qualifier mix: model tracking plus the one-bit-step property.
        for (int k = 0; k < 96; k++) begin
            prev = gray_pointer;
            i    = ($urandom_range(0, 3) != 0);
            q    = ($urandom_range(0, 3) != 0);
            drive(i, q);
            tick();
            if (i && q)
                check("one_bit", $countones(prev ^ gray_pointer), 1);
            else
                check("held", int'(gray_pointer), gray_of(count));
            if (k == 50) begin
                #2;
                async_reset();
            end
        end

        // Enabled run from a nonzero state must resume correctly after reset.
        drive(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) tick();
        #4;
        async_reset();
        drive(1'b1, 1'b1);
        tick();
        check("resume_addr", int'(binary_address), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_gray_counter
